or1k_spr_access: RTL and testbench
==================================

Name: or1k_spr_access

Overview:
- Downstream consumer of the configuration SPR block. Serves l.mfspr/l.mtspr requests from the control stage.
- Group-0 configuration registers (VR..AVR) are answered locally from the configuration inputs.
- All other SPR addresses go to the external SPR bus through a strobe/ack handshake with a timeout.
- Returns a registered single-cycle acknowledge, read data and an error flag to the control stage.

Parameters:
- OPTION_SPR_TIMEOUT, 15, bus cycles to wait for spr_bus_ack_i before an error is flagged; legal range 2..255.
- OPTION_OPERAND_WIDTH, 32, SPR data width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous assert, active low.
- spr_req_i  in  1  request valid; held until spr_ack_o.
- spr_we_i  in  1  1 = mtspr, 0 = mfspr.
- spr_addr_i  in  16  {group[15:11], index[10:0]}.
- spr_wdata_i  in  32  write data.
- spr_ack_o  out  1  one-cycle completion pulse.
- spr_rdata_o  out  32  read data; valid while spr_ack_o = 1.
- spr_err_o  out  1  error qualifier; valid while spr_ack_o = 1.
- cfg_vr_i, cfg_upr_i, cfg_cpucfgr_i, cfg_dmmucfgr_i, cfg_immucfgr_i, cfg_dccfgr_i, cfg_iccfgr_i, cfg_dcfgr_i, cfg_pccfgr_i, cfg_vr2_i, cfg_avr_i  in  32 each  static configuration SPR values.
- spr_bus_stb_o  out  1  external bus strobe.
- spr_bus_we_o  out  1  external bus write enable.
- spr_bus_addr_o  out  16  external bus address.
- spr_bus_dat_o  out  32  external bus write data.
- spr_bus_ack_i  in  1  external bus acknowledge.
- spr_bus_dat_i  in  32  external bus read data.

Behaviour:
- Reset: state IDLE; spr_ack_o, spr_err_o, spr_bus_stb_o, spr_bus_we_o = 0; spr_rdata_o, spr_bus_addr_o, spr_bus_dat_o = 0; timeout counter = 0.
- Local address: group 0 with index 0..10. Index map: VR=0, UPR=1, CPUCFGR=2, DMMUCFGR=3, IMMUCFGR=4, DCCFGR=5, ICCFGR=6, DCFGR=7, PCCFGR=8, VR2=9, AVR=10.
- Every other address, including group 0 index >= 11, is a bus address.
- FSM states: IDLE, BUS, DONE.
- IDLE, spr_req_i = 1, local address:
  - read: spr_rdata_o <= selected cfg input; go to DONE.
  - write: data discarded, spr_rdata_o <= 0; go to DONE.
  - Latency: request at cycle N, ack at N+1.
- IDLE, spr_req_i = 1, bus address: latch addr, we and wdata onto the bus outputs; spr_bus_stb_o <= 1; counter <= 0; go to BUS. Strobe is visible at N+1.
- BUS, spr_bus_ack_i = 1: stb <= 0; spr_rdata_o <= spr_bus_dat_i on reads, 0 on writes; err <= 0; go to DONE.
- BUS, spr_bus_ack_i = 0 and counter == OPTION_SPR_TIMEOUT-1: stb <= 0; rdata <= 0; err <= 1; go to DONE.
- BUS, otherwise: counter increments; stb and bus outputs held stable.
- Ack and timeout in the same cycle: ack wins, err = 0.
- DONE: spr_ack_o = 1 for exactly one cycle; spr_req_i is ignored; next state IDLE. In every other state spr_ack_o = 0 and spr_err_o = 0.
- Requester drops spr_req_i in the cycle it sees spr_ack_o. Back-to-back throughput: local 2 cycles; bus 3 + wait cycles.
- spr_bus_ack_i outside BUS is ignored.
- spr_req_i, spr_addr_i and spr_we_i are sampled only in IDLE. Changes while in BUS or DONE have no effect.
- Async reset mid-transaction: immediate return to IDLE, strobe dropped, no ack issued.

Optional Feature:
- Macro OR1K_SPR_RO_WRITE_ERR_EN.
- Defined: a write to a local (read-only) address completes with spr_err_o = 1 alongside spr_ack_o.
- Undefined: the write is silently ignored with spr_err_o = 0.
- Timing is identical in both builds.

Decomposition:
- Package or1k_spr_pkg holds:
  - group-0 index constants (VR..AVR = 0..10) and the group field slice [15:11];
  - state enum {IDLE, BUS, DONE};
  - timeout counter width, computed as clog2(OPTION_SPR_TIMEOUT).
- One sub-module, or1k_spr_local_mux: combinational decode producing is_local and the selected 32-bit cfg value.
- The FSM, counter and bus registers stay in the top module.

Test Plan:
- Read addr 0x0000 with cfg_vr_i = 0x10000040 → spr_ack_o one cycle after the request, rdata 0x10000040, err 0.
- Read addr 0x000A with cfg_avr_i = 0x01010000 → ack at N+1, rdata 0x01010000.
- Write 0x0001 with data 0xDEADBEEF → ack at N+1; err 0 without the macro, err 1 with it; no strobe in either build.
- Read addr 0x2800; bus acks 3 cycles after the strobe with 0xCAFEF00D → stb high 4 cycles; ack the cycle after bus ack; rdata 0xCAFEF00D; err 0.
- Read addr 0x4801, bus silent, OPTION_SPR_TIMEOUT = 15 → stb high 15 cycles, then ack with err 1, rdata 0. A second run with bus ack on the final timeout cycle → err 0, rdata captured.
- Assert rst_n = 0 while in BUS → stb and ack 0 immediately; after release, a new local read completes normally.

Source files
------------

// File: rtl/or1k_spr_access_pkg.sv
// Shared constants for the SPR access path: group-0 configuration index map,
// FSM state encoding and timeout counter sizing.
package or1k_spr_pkg;

  localparam int unsigned GroupMsb = 15;
  localparam int unsigned GroupLsb = 11;

  localparam logic [10:0] IdxVr       = 11'd0;
  localparam logic [10:0] IdxUpr      = 11'd1;
  localparam logic [10:0] IdxCpucfgr  = 11'd2;
  localparam logic [10:0] IdxDmmucfgr = 11'd3;
  localparam logic [10:0] IdxImmucfgr = 11'd4;
  localparam logic [10:0] IdxDccfgr   = 11'd5;
  localparam logic [10:0] IdxIccfgr   = 11'd6;
  localparam logic [10:0] IdxDcfgr    = 11'd7;
  localparam logic [10:0] IdxPccfgr   = 11'd8;
  localparam logic [10:0] IdxVr2      = 11'd9;
  localparam logic [10:0] IdxAvr      = 11'd10;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Counter only needs to reach timeout-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/or1k_spr_access_if.sv
// Control-stage request channel plus external SPR bus, as seen by or1k_spr_access.
interface or1k_spr_access_if #(
    parameter int unsigned Width = 32
);
    logic             spr_req;
    logic             spr_we;
    logic [15:0]      spr_addr;
    logic [Width-1:0] spr_wdata;
    logic             spr_ack;
    logic [Width-1:0] spr_rdata;
    logic             spr_err;
    logic             spr_bus_stb;
    logic             spr_bus_we;
    logic [15:0]      spr_bus_addr;
    logic [Width-1:0] spr_bus_wdata;
    logic             spr_bus_ack;
    logic [Width-1:0] spr_bus_rdata;

    modport slave (
        input  spr_req, spr_we, spr_addr, spr_wdata, spr_bus_ack, spr_bus_rdata,
        output spr_ack, spr_rdata, spr_err, spr_bus_stb, spr_bus_we, spr_bus_addr,
               spr_bus_wdata
    );

    modport master (
        output spr_req, spr_we, spr_addr, spr_wdata, spr_bus_ack, spr_bus_rdata,
        input  spr_ack, spr_rdata, spr_err, spr_bus_stb, spr_bus_we, spr_bus_addr,
               spr_bus_wdata
    );
endinterface

// File: rtl/or1k_spr_access_local_mux.sv
// Decodes group-0 configuration addresses (VR..AVR) and selects the matching cfg value.
module or1k_spr_local_mux
    import or1k_spr_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic [15:0]      addr_i,
    input  logic [Width-1:0] cfg_vr_i,
    input  logic [Width-1:0] cfg_upr_i,
    input  logic [Width-1:0] cfg_cpucfgr_i,
    input  logic [Width-1:0] cfg_dmmucfgr_i,
    input  logic [Width-1:0] cfg_immucfgr_i,
    input  logic [Width-1:0] cfg_dccfgr_i,
    input  logic [Width-1:0] cfg_iccfgr_i,
    input  logic [Width-1:0] cfg_dcfgr_i,
    input  logic [Width-1:0] cfg_pccfgr_i,
    input  logic [Width-1:0] cfg_vr2_i,
    input  logic [Width-1:0] cfg_avr_i,
    output logic             is_local_o,
    output logic [Width-1:0] cfg_data_o
);
    always_comb begin
        is_local_o = (addr_i[GroupMsb:GroupLsb] == 5'd0) && (addr_i[10:0] <= IdxAvr);
        cfg_data_o = '0;
        case (addr_i[10:0])
            IdxVr:       cfg_data_o = cfg_vr_i;
            IdxUpr:      cfg_data_o = cfg_upr_i;
            IdxCpucfgr:  cfg_data_o = cfg_cpucfgr_i;
            IdxDmmucfgr: cfg_data_o = cfg_dmmucfgr_i;
            IdxImmucfgr: cfg_data_o = cfg_immucfgr_i;
            IdxDccfgr:   cfg_data_o = cfg_dccfgr_i;
            IdxIccfgr:   cfg_data_o = cfg_iccfgr_i;
            IdxDcfgr:    cfg_data_o = cfg_dcfgr_i;
            IdxPccfgr:   cfg_data_o = cfg_pccfgr_i;
            IdxVr2:      cfg_data_o = cfg_vr2_i;
            IdxAvr:      cfg_data_o = cfg_avr_i;
            default:     cfg_data_o = '0;
        endcase
    end
endmodule

// File: rtl/or1k_spr_access.sv
// l.mfspr/l.mtspr server: group-0 config SPRs answered locally, others via the SPR bus
// with timeout. Define OR1K_SPR_RO_WRITE_ERR_EN to flag writes to local SPRs as errors.
module or1k_spr_access
    import or1k_spr_pkg::*;
#(
    parameter int unsigned OPTION_SPR_TIMEOUT   = 15,
    parameter int unsigned OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    or1k_spr_access_if.slave                spr_io,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_vr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_upr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_cpucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_dmmucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_immucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_dccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_iccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_dcfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_pccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_vr2_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cfg_avr_i
);
    localparam int unsigned W    = OPTION_OPERAND_WIDTH;
    localparam int unsigned CntW = cnt_width(OPTION_SPR_TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(OPTION_SPR_TIMEOUT - 1);
`ifdef OR1K_SPR_RO_WRITE_ERR_EN
    localparam logic RoWriteErr = 1'b1;
`else
    localparam logic RoWriteErr = 1'b0;
`endif

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ack_q, ack_d, err_q, err_d;
    logic [W-1:0]    rdata_q, rdata_d;
    logic            stb_q, stb_d, bus_we_q, bus_we_d;
    logic [15:0]     bus_addr_q, bus_addr_d;
    logic [W-1:0]    bus_wdata_q, bus_wdata_d;
    logic            is_local;
    logic [W-1:0]    cfg_data;

    or1k_spr_local_mux #(.Width(W)) u_local_mux (
        .addr_i         (spr_io.spr_addr),
        .cfg_vr_i       (cfg_vr_i),
        .cfg_upr_i      (cfg_upr_i),
        .cfg_cpucfgr_i  (cfg_cpucfgr_i),
        .cfg_dmmucfgr_i (cfg_dmmucfgr_i),
        .cfg_immucfgr_i (cfg_immucfgr_i),
        .cfg_dccfgr_i   (cfg_dccfgr_i),
        .cfg_iccfgr_i   (cfg_iccfgr_i),
        .cfg_dcfgr_i    (cfg_dcfgr_i),
        .cfg_pccfgr_i   (cfg_pccfgr_i),
        .cfg_vr2_i      (cfg_vr2_i),
        .cfg_avr_i      (cfg_avr_i),
        .is_local_o     (is_local),
        .cfg_data_o     (cfg_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        stb_d       = stb_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        case (state_q)
            StIdle: begin
                if (spr_io.spr_req) begin
                    if (is_local) begin
                        rdata_d = spr_io.spr_we ? '0 : cfg_data;
                        err_d   = spr_io.spr_we & RoWriteErr;
                        ack_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        bus_addr_d  = spr_io.spr_addr;
                        bus_we_d    = spr_io.spr_we;
                        bus_wdata_d = spr_io.spr_wdata;
                        stb_d       = 1'b1;
                        cnt_d       = '0;
                        state_d     = StBus;
                    end
                end
            end
            StBus: begin
                // A bus ack takes priority over an expiring timeout.
                if (spr_io.spr_bus_ack) begin
                    stb_d   = 1'b0;
                    rdata_d = bus_we_q ? '0 : spr_io.spr_bus_rdata;
                    ack_d   = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    stb_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            stb_q       <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            stb_q       <= stb_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign spr_io.spr_ack       = ack_q;
    assign spr_io.spr_err       = err_q;
    assign spr_io.spr_rdata     = rdata_q;
    assign spr_io.spr_bus_stb   = stb_q;
    assign spr_io.spr_bus_we    = bus_we_q;
    assign spr_io.spr_bus_addr  = bus_addr_q;
    assign spr_io.spr_bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_or1k_spr_access.sv
// Self-checking bench for or1k_spr_access: directed table, random transactions against a
// transaction-level model, and a mid-transaction reset sequence.
module tb_or1k_spr_access;
    localparam int unsigned T = 15;
`ifdef OR1K_SPR_RO_WRITE_ERR_EN
    localparam bit RoErr = 1'b1;
`else
    localparam bit RoErr = 1'b0;
`endif
    localparam int Never = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] cfg_m [11];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    or1k_spr_access_if #(.Width(32)) spr_if ();

    or1k_spr_access #(.OPTION_SPR_TIMEOUT(T), .OPTION_OPERAND_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spr_io         (spr_if),
        .cfg_vr_i       (cfg_m[0]),
        .cfg_upr_i      (cfg_m[1]),
        .cfg_cpucfgr_i  (cfg_m[2]),
        .cfg_dmmucfgr_i (cfg_m[3]),
        .cfg_immucfgr_i (cfg_m[4]),
        .cfg_dccfgr_i   (cfg_m[5]),
        .cfg_iccfgr_i   (cfg_m[6]),
        .cfg_dcfgr_i    (cfg_m[7]),
        .cfg_pccfgr_i   (cfg_m[8]),
        .cfg_vr2_i      (cfg_m[9]),
        .cfg_avr_i      (cfg_m[10])
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] bdat;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_stb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: local SPRs answer next cycle; bus SPRs wait for the
    // bus ack (delay cycles into the strobe) or give up after T strobe cycles.
    task automatic model(inout vec_t v);
        bit local_a;
        local_a = (v.addr[15:11] == 5'd0) && (v.addr[10:0] <= 11'd10);
        if (local_a) begin
            v.e_stb   = 0;
            v.e_lat   = 1;
            v.e_rdata = v.we ? 32'h0 : cfg_m[v.addr[3:0]];
            v.e_err   = v.we & RoErr;
        end else if (v.delay < int'(T)) begin
            v.e_stb   = v.delay + 1;
            v.e_lat   = v.e_stb + 1;
            v.e_rdata = v.we ? 32'h0 : v.bdat;
            v.e_err   = 1'b0;
        end else begin
            v.e_stb   = T;
            v.e_lat   = T + 1;
            v.e_rdata = 32'h0;
            v.e_err   = 1'b1;
        end
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int cycles;
        int stb_cnt;
        bit got;
        cycles  = 0;
        stb_cnt = 0;
        got     = 1'b0;
        @(negedge clk);
        spr_if.spr_req     = 1'b1;
        spr_if.spr_we      = v.we;
        spr_if.spr_addr    = v.addr;
        spr_if.spr_wdata   = v.wdata;
        spr_if.spr_bus_ack = 1'b0;
        while (!got && cycles < 100) begin
            @(negedge clk);
            cycles++;
            // Scramble request inputs after issue; they must not matter outside idle.
            spr_if.spr_addr  = 16'($urandom);
            spr_if.spr_we    = 1'($urandom);
            spr_if.spr_wdata = $urandom;
            if (spr_if.spr_ack) begin
                got = 1'b1;
                chk({name, ".lat"}, 32'(cycles), 32'(v.e_lat));
                chk({name, ".rdata"}, spr_if.spr_rdata, v.e_rdata);
                chk({name, ".err"}, 32'(spr_if.spr_err), 32'(v.e_err));
                chk({name, ".stb_cycles"}, 32'(stb_cnt), 32'(v.e_stb));
                spr_if.spr_req     = 1'b0;
                spr_if.spr_bus_ack = 1'b1;  // stray bus ack outside BUS must be ignored
                spr_if.spr_bus_rdata = 32'hBAD0BAD0;
            end else if (spr_if.spr_bus_stb) begin
                if (stb_cnt == 0) begin
                    chk({name, ".bus_addr"}, 32'(spr_if.spr_bus_addr), 32'(v.addr));
                    chk({name, ".bus_we"}, 32'(spr_if.spr_bus_we), 32'(v.we));
                    chk({name, ".bus_dat"}, spr_if.spr_bus_wdata, v.wdata);
                end
                spr_if.spr_bus_ack   = (stb_cnt == v.delay);
                spr_if.spr_bus_rdata = v.bdat;
                stb_cnt++;
            end else begin
                spr_if.spr_bus_ack = 1'b0;
            end
        end
        if (!got) chk({name, ".ack_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({name, ".ack_single"}, 32'(spr_if.spr_ack), 32'd0);
        chk({name, ".stb_idle"}, 32'(spr_if.spr_bus_stb), 32'd0);
        spr_if.spr_bus_ack = 1'b0;
    endtask

    vec_t vecs [8];
    vec_t rv;

    initial begin
        cfg_m[0]  = 32'h10000040;
        cfg_m[10] = 32'h01010000;
        for (int i = 1; i < 10; i++) cfg_m[i] = 32'hC0F00000 | 32'(i * 32'h111);
        spr_if.spr_req       = 1'b0;
        spr_if.spr_we        = 1'b0;
        spr_if.spr_addr      = 16'h0;
        spr_if.spr_wdata     = 32'h0;
        spr_if.spr_bus_ack   = 1'b0;
        spr_if.spr_bus_rdata = 32'h0;

        vecs[0] = '{16'h0000, 1'b0, 32'h0,        0,     32'h0,        32'h10000040, 1'b0,  1,  0};
        vecs[1] = '{16'h000A, 1'b0, 32'h0,        0,     32'h0,        32'h01010000, 1'b0,  1,  0};
        vecs[2] = '{16'h0001, 1'b1, 32'hDEADBEEF, 0,     32'h0,        32'h0,        RoErr, 1,  0};
        vecs[3] = '{16'h2800, 1'b0, 32'h0,        3,     32'hCAFEF00D, 32'hCAFEF00D, 1'b0,  5,  4};
        vecs[4] = '{16'h4801, 1'b0, 32'h0,        Never, 32'h0,        32'h0,        1'b1,  16, 15};
        vecs[5] = '{16'h4801, 1'b0, 32'h0,        14,    32'h12345678, 32'h12345678, 1'b0,  16, 15};
        vecs[6] = '{16'h000B, 1'b1, 32'hA5A5A5A5, 0,     32'h0,        32'h0,        1'b0,  2,  1};
        vecs[7] = '{16'h0809, 1'b1, 32'h5A5A0001, Never, 32'h0,        32'h0,        1'b1,  16, 15};

        #2;
        chk("reset.ack", 32'(spr_if.spr_ack), 32'd0);
        chk("reset.err", 32'(spr_if.spr_err), 32'd0);
        chk("reset.stb", 32'(spr_if.spr_bus_stb), 32'd0);
        chk("reset.bus_we", 32'(spr_if.spr_bus_we), 32'd0);
        chk("reset.rdata", spr_if.spr_rdata, 32'h0);
        chk("reset.bus_addr", 32'(spr_if.spr_bus_addr), 32'h0);
        chk("reset.bus_dat", spr_if.spr_bus_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("dir%0d", i));

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) rv.addr = 16'($urandom_range(0, 10));
            else begin
                rv.addr = 16'($urandom);
                if (rv.addr[15:11] == 5'd0 && rv.addr[10:0] <= 11'd10) rv.addr[10:0] = 11'd11;
            end
            rv.we    = 1'($urandom);
            rv.wdata = $urandom;
            rv.delay = $urandom_range(0, 18);
            rv.bdat  = $urandom;
            model(rv);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Reset while the bus strobe is up.
        @(negedge clk);
        spr_if.spr_req  = 1'b1;
        spr_if.spr_we   = 1'b0;
        spr_if.spr_addr = 16'h4801;
        repeat (3) @(negedge clk);
        chk("rst_mid.stb_before", 32'(spr_if.spr_bus_stb), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.stb", 32'(spr_if.spr_bus_stb), 32'd0);
        chk("rst_mid.ack", 32'(spr_if.spr_ack), 32'd0);
        spr_if.spr_req = 1'b0;
        @(negedge clk);
        chk("rst_mid.ack_held", 32'(spr_if.spr_ack), 32'd0);
        rst_n = 1'b1;
        run_txn(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
